// File: rtl/ram_bus_arbiter.sv
// Round-robin arbiter sharing one RAM port among the icache/dcache of two CPUs.
// Optional watchdog on stuck transfers is compiled in with `define ARB_TIMEOUT_EN.
module ram_bus_arbiter #(
  parameter int CPUS           = 2,
  parameter int WORD_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [CPUS-1:0]              iREN,
  input  logic [CPUS-1:0]              dREN,
  input  logic [CPUS-1:0]              dWEN,
  input  logic [CPUS-1:0][WORD_W-1:0]  iaddr,
  input  logic [CPUS-1:0][WORD_W-1:0]  daddr,
  input  logic [CPUS-1:0][WORD_W-1:0]  dstore,
  output logic [CPUS-1:0]              iwait,
  output logic [CPUS-1:0]              dwait,
  output logic [CPUS-1:0][WORD_W-1:0]  iload,
  output logic [CPUS-1:0][WORD_W-1:0]  dload,
  input  logic [1:0]                   ramstate,
  input  logic [WORD_W-1:0]            ramload,
  output logic                         ramREN,
  output logic                         ramWEN,
  output logic [WORD_W-1:0]            ramaddr,
  output logic [WORD_W-1:0]            ramstore,
  output logic                         owner_cpu,
  output logic                         busy,
  output logic                         bus_err,
  output logic                         dbg_state
);

  // Handshake: a cache raises its request with stable address/data and holds it
  // until it sees its wait low; that single cycle transfers the word (iload/dload
  // valid only then). Dropping a request before that cancels it without an ack.

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  state_t          state, state_nxt;
  logic            rr_ptr, rr_nxt;
  logic            own_cpu, own_cpu_nxt;
  logic            own_d, own_d_nxt;
  logic            own_w, own_w_nxt;

  logic [CPUS-1:0] dreq, ireq, anyreq;
  logic            pick_cpu;
  logic            req_live;
  logic            st_access, st_error;
  logic            timeout_hit;

  assign dreq      = dREN | dWEN;
  assign ireq      = iREN;
  assign anyreq    = dreq | ireq;
  assign pick_cpu  = anyreq[rr_ptr] ? rr_ptr : ~rr_ptr;
  assign req_live  = own_d ? dreq[own_cpu] : ireq[own_cpu];
  assign st_access = (ramstate == RS_ACCESS);
  assign st_error  = (ramstate == RS_ERROR);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;

  // Counts GRANT cycles that ended without ACCESS; idle time keeps it cleared.
  always_ff @(posedge CLK) begin
    if (RST || state != GRANT) begin
      to_cnt <= '0;
    end else if (!st_access) begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end

  assign timeout_hit = (state == GRANT) && !st_access &&
                       (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog compiled out; the limit never matches so GRANT waits indefinitely.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      rr_ptr  <= 1'b0;
      own_cpu <= 1'b0;
      own_d   <= 1'b0;
      own_w   <= 1'b0;
    end else begin
      state   <= state_nxt;
      rr_ptr  <= rr_nxt;
      own_cpu <= own_cpu_nxt;
      own_d   <= own_d_nxt;
      own_w   <= own_w_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rr_nxt      = rr_ptr;
    own_cpu_nxt = own_cpu;
    own_d_nxt   = own_d;
    own_w_nxt   = own_w;
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    bus_err     = 1'b0;

    case (state)
      IDLE: begin
        if (|anyreq) begin
          own_cpu_nxt = pick_cpu;
          own_d_nxt   = dreq[pick_cpu];
          own_w_nxt   = dWEN[pick_cpu];
          state_nxt   = GRANT;
        end
      end

      GRANT: begin
        ramaddr  = own_d ? daddr[own_cpu] : iaddr[own_cpu];
        ramstore = own_d ? dstore[own_cpu] : '0;
        if (!req_live) begin
          // Cancelled by the owner: release the bus, keep the turn order.
          state_nxt = IDLE;
        end else begin
          ramWEN = own_w;
          ramREN = ~own_w;
          if (st_access) begin
            if (own_d) begin
              dwait[own_cpu] = 1'b0;
              dload[own_cpu] = ramload;
            end else begin
              iwait[own_cpu] = 1'b0;
              iload[own_cpu] = ramload;
            end
            state_nxt = IDLE;
            rr_nxt    = ~own_cpu;
          end else if (st_error || timeout_hit) begin
            bus_err   = 1'b1;
            state_nxt = IDLE;
            rr_nxt    = ~own_cpu;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign owner_cpu = own_cpu;
  assign busy      = (state == GRANT);
  assign dbg_state = state;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Randomized bench for ram_bus_arbiter: cache/RAM behaviour model feeding a
// per-cycle expected queue, checked by an independent negedge monitor.
module tb_ram_bus_arbiter;
  localparam int W     = 32;
  localparam int TO    = 64;
  localparam int N_CYC = 3000;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]        iREN, dREN, dWEN;
  logic [1:0][W-1:0] iaddr, daddr, dstore;
  logic [1:0]        iwait, dwait;
  logic [1:0][W-1:0] iload, dload;
  logic [1:0]        ramstate;
  logic [W-1:0]      ramload;
  logic              ramREN, ramWEN;
  logic [W-1:0]      ramaddr, ramstore;
  logic              owner_cpu, busy, bus_err, dbg_state;

  always #5 clk = ~clk;

  ram_bus_arbiter #(.CPUS(2), .WORD_W(W), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(clk), .RST(rst),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramstate(ramstate), .ramload(ramload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .owner_cpu(owner_cpu), .busy(busy), .bus_err(bus_err), .dbg_state(dbg_state)
  );

  typedef struct packed {
    logic         busy;
    logic         owner;
    logic [1:0]   iw;
    logic [1:0]   dw;
    logic         berr;
    logic         ren;
    logic         wen;
    logic         chk_addr;
    logic [W-1:0] addr;
    logic         chk_store;
    logic [W-1:0] store;
    logic [W-1:0] ld;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic [EXP_W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_txn   = 0;
  int n_ack_seen = 0;
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  exp_t me;
  initial begin
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        me = exp_t'(exp_q.pop_front());
        check("busy", busy, me.busy);
        check("dbg_state", dbg_state, me.busy);
        if (me.busy) check("owner_cpu", owner_cpu, me.owner);
        check("iwait", iwait, me.iw);
        check("dwait", dwait, me.dw);
        check("one_wait_low", ($countones(~{iwait, dwait}) > 1), 0);
        check("bus_err", bus_err, me.berr);
        check("ramREN", ramREN, me.ren);
        check("ramWEN", ramWEN, me.wen);
        if (me.chk_addr) check("ramaddr", ramaddr, me.addr);
        if (me.chk_store) check("ramstore", ramstore, me.store);
        for (int c = 0; c < 2; c++) begin
          check("iload", iload[c], me.iw[c] ? '0 : me.ld);
          check("dload", dload[c], me.dw[c] ? '0 : me.ld);
        end
        if (|(~{iwait, dwait})) n_ack_seen++;
      end
    end
  end

  // Model state: bus owner, remaining RAM latency, turn pointer.
  logic       m_grant, m_owner, m_d, m_w, m_rr, m_err, m_long, want_long;
  int         m_lat, m_gcnt, kind;
  logic       ack_v, ack_c, ack_d, win;
  logic [1:0] pi, pd;
  exp_t       se;

  initial begin
    rst = 1'b1;
    iREN = 2'b11; dREN = 2'b11; dWEN = 2'b00;
    for (int c = 0; c < 2; c++) begin
      iaddr[c] = $urandom; daddr[c] = $urandom; dstore[c] = $urandom;
    end
    ramstate = 2'd0; ramload = '0;
    m_grant = 0; m_owner = 0; m_d = 0; m_w = 0; m_rr = 0; m_err = 0;
    m_long = 0; want_long = 0; m_lat = 0; m_gcnt = 0; ack_v = 0; ack_c = 0; ack_d = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_iwait", iwait, 2'b11);
    check("rst_dwait", dwait, 2'b11);
    check("rst_ramREN", ramREN, 0);
    check("rst_ramWEN", ramWEN, 0);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_ramstore", ramstore, 0);
    check("rst_busy", busy, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_owner", owner_cpu, 0);
    check("rst_iload", iload, 0);
    check("rst_dload", dload, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      if (cyc == 2000) want_long = 1'b1;
      // Caches: retire the word acked last cycle, then maybe issue new requests.
      if (ack_v) begin
        if (ack_d) begin dREN[ack_c] = 1'b0; dWEN[ack_c] = 1'b0; end
        else iREN[ack_c] = 1'b0;
        ack_v = 1'b0;
      end
      for (int c = 0; c < 2; c++) begin
        if (!iREN[c] && $urandom_range(0, 2) == 0) begin
          iREN[c] = 1'b1; iaddr[c] = $urandom;
        end
        if (!(dREN[c] | dWEN[c]) && $urandom_range(0, 2) == 0) begin
          daddr[c] = $urandom; dstore[c] = $urandom;
          kind = $urandom_range(0, 2);
          dREN[c] = (kind != 1);
          dWEN[c] = (kind != 0);
        end
      end
      if (m_grant && m_lat > 0 && !m_long && $urandom_range(0, 15) == 0) begin
        if (m_d) begin dREN[m_owner] = 1'b0; dWEN[m_owner] = 1'b0; end
        else iREN[m_owner] = 1'b0;
      end
      pi = iREN;
      pd = dREN | dWEN;

      se = '0;
      se.iw = 2'b11;
      se.dw = 2'b11;
      ramload = $urandom;
      if (!m_grant) begin
        ramstate = 2'($urandom_range(0, 3));
        if (|(pi | pd)) begin
          win = (pi[m_rr] | pd[m_rr]) ? m_rr : ~m_rr;
          m_owner = win;
          m_d = pd[win];
          m_w = pd[win] & dWEN[win];
          m_lat = $urandom_range(0, 2);
          m_err = ($urandom_range(0, 9) == 0);
          m_gcnt = 0;
          m_long = 1'b0;
          if (want_long) begin
            m_lat = 150; m_err = 1'b0; m_long = 1'b1; want_long = 1'b0;
          end
          m_grant = 1'b1;
        end
      end else begin
        se.busy = 1'b1;
        se.owner = m_owner;
        se.chk_addr = 1'b1;
        se.addr = m_d ? daddr[m_owner] : iaddr[m_owner];
        if (!(m_d ? pd[m_owner] : pi[m_owner])) begin
          ramstate = 2'($urandom_range(0, 3));
          m_grant = 1'b0;
        end else begin
          se.ren = !m_w;
          se.wen = m_w;
          if (m_w) begin se.chk_store = 1'b1; se.store = dstore[m_owner]; end
          if (m_lat > 0) begin
            ramstate = 2'($urandom_range(0, 1));
`ifdef ARB_TIMEOUT_EN
            if (m_gcnt == TO - 1) begin
              se.berr = 1'b1; m_grant = 1'b0; m_rr = ~m_owner;
            end
`endif
            m_lat--;
            m_gcnt++;
          end else if (m_err) begin
            ramstate = RS_ERROR;
            se.berr = 1'b1;
            m_grant = 1'b0;
            m_rr = ~m_owner;
          end else begin
            ramstate = RS_ACCESS;
            se.ld = ramload;
            if (m_d) se.dw[m_owner] = 1'b0;
            else se.iw[m_owner] = 1'b0;
            ack_v = 1'b1; ack_c = m_owner; ack_d = m_d;
            m_grant = 1'b0;
            m_rr = ~m_owner;
            n_txn++;
          end
        end
      end
      exp_q.push_back(EXP_W'(se));
      @(posedge clk);
      #1;
    end

    check("queue_drained", exp_q.size(), 0);
    check("ack_count", n_ack_seen, n_txn);
    check("txn_progress", (n_txn > 100), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
